// File: rtl/asyn_fifo_pkg.sv
// Shared types, sizes and pointer helpers for the 16x8 async FIFO.
// Used by both the write-side and read-side controllers.
package asyn_fifo_pkg;

  localparam int RAM_WIDTH    = 16;
  localparam int RAM_DEPTH    = 8;
  localparam int ADDR_SIZE    = 3;
  localparam int PTR_W        = ADDR_SIZE + 1;
  localparam int AFULL_THRESH = 6;

  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/asyn_fifo_gray_ptr_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Reused by the read side for the write pointer.
module gray_ptr_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  // Two back-to-back flops; only the second stage is consumed.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/asyn_fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: pointers, full, occupancy.
// Optional almost_full flag built only when ALMOST_FULL_EN is defined.
module asyn_fifo_wr_ctrl
  import asyn_fifo_pkg::*;
#(
  parameter int RAM_WIDTH    = 16,
  parameter int RAM_DEPTH    = 8,
  parameter int ADDR_SIZE    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 wr_clk,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic [RAM_WIDTH-1:0] in_data,
  output logic                 in_ready,
  input  logic [ADDR_SIZE:0]   rd_ptr_gray,
  output logic                 ram_wr_en,
  output logic [ADDR_SIZE-1:0] ram_wr_ad,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  output logic [ADDR_SIZE:0]   wr_ptr_gray,
  output logic                 full,
  output logic [ADDR_SIZE:0]   wr_count,
  output logic                 almost_full
);

  localparam int PW = ADDR_SIZE + 1;

  if (RAM_DEPTH != (1 << ADDR_SIZE) ||
      AFULL_THRESH > RAM_DEPTH) begin : g_bad_cfg
    $error("asyn_fifo_wr_ctrl: bad depth/threshold");
  end

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] count_next;
  logic          accept;
  logic          full_next;

  gray_ptr_sync #(
    .WIDTH(PW)
  ) u_rsync (
    .clk(wr_clk),
    .clr(clr),
    .d  (rd_ptr_gray),
    .q  (rq2)
  );

  assign accept      = in_valid & ~full;
  assign in_ready    = ~full;
  assign ram_wr_en   = accept;
  assign ram_wr_ad   = wr_bin[ADDR_SIZE-1:0];
  assign ram_data_in = in_data;

  assign wr_bin_next = wr_bin + PW'(accept);
  assign gray_next   = bin2gray(wr_bin_next);
  assign rd_bin      = gray2bin(rq2);
  assign full_next   = gray_next ==
                       {~rq2[PW-1:PW-2], rq2[PW-3:0]};
  assign count_next  = wr_bin_next - rd_bin;

  // Advance the write pointer and register full/occupancy.
  always_ff @(posedge wr_clk or posedge clr) begin
    if (clr) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      wr_count    <= '0;
    end else begin
      wr_bin      <= wr_bin_next;
      wr_ptr_gray <= gray_next;
      full        <= full_next;
      wr_count    <= count_next;
    end
  end

`ifdef ALMOST_FULL_EN
  // Registered threshold compare on next-cycle occupancy.
  always_ff @(posedge wr_clk or posedge clr) begin
    if (clr)
      almost_full <= 1'b0;
    else
      almost_full <= (count_next >= PW'(AFULL_THRESH));
  end
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_asyn_fifo_wr_ctrl.sv
// Directed self-checking bench for asyn_fifo_wr_ctrl.
// Expected values are hand-derived per scenario.
module tb_asyn_fifo_wr_ctrl;

  logic        wr_clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [3:0]  rd_ptr_gray;
  logic        ram_wr_en;
  logic [2:0]  ram_wr_ad;
  logic [15:0] ram_data_in;
  logic [3:0]  wr_ptr_gray;
  logic        full;
  logic [3:0]  wr_count;
  logic        almost_full;

  int checks = 0;
  int passed = 0;
  int beef_writes = 0;

  asyn_fifo_wr_ctrl dut (
    .wr_clk     (wr_clk),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rd_ptr_gray(rd_ptr_gray),
    .ram_wr_en  (ram_wr_en),
    .ram_wr_ad  (ram_wr_ad),
    .ram_data_in(ram_data_in),
    .wr_ptr_gray(wr_ptr_gray),
    .full       (full),
    .wr_count   (wr_count),
    .almost_full(almost_full)
  );

  always #5 wr_clk = ~wr_clk;

  always @(posedge wr_clk)
    if (ram_wr_en && ram_data_in == 16'hBEEF)
      beef_writes++;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  function automatic logic [3:0] g(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  task automatic tick;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_clr;
    clr = 1'b1;
    in_valid = 1'b0;
    rd_ptr_gray = 4'h0;
    tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    clr = 1'b0;
    in_valid = 1'b0;
    in_data = 16'h0;
    rd_ptr_gray = 4'h0;
    #2;
    clr = 1'b1;
    #1;
    checks++;
    if (full !== 1'b0)
      $display("FAIL reset_full got %b exp 0", full);
    else passed++;
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_ready got %b exp 1", in_ready);
    else passed++;
    checks++;
    if (wr_count !== 4'd0)
      $display("FAIL reset_count got %0d exp 0", wr_count);
    else passed++;
    checks++;
    if (wr_ptr_gray !== 4'b0000)
      $display("FAIL reset_gray got %b exp 0000", wr_ptr_gray);
    else passed++;
    checks++;
    if (almost_full !== 1'b0)
      $display("FAIL reset_af got %b exp 0", almost_full);
    else passed++;
    tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic test_fill;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data = 16'h1000 + 16'(k);
      #1;
      checks++;
      if (ram_wr_en !== (k < 8))
        $display("FAIL fill_we[%0d] got %b exp %b",
                 k, ram_wr_en, (k < 8));
      else passed++;
      if (k < 8) begin
        checks++;
        if (ram_wr_ad !== 3'(k))
          $display("FAIL fill_ad[%0d] got %0d exp %0d",
                   k, ram_wr_ad, k);
        else passed++;
        checks++;
        if (ram_data_in !== 16'h1000 + 16'(k))
          $display("FAIL fill_data[%0d] got %h exp %h",
                   k, ram_data_in, 16'h1000 + 16'(k));
        else passed++;
      end
      tick();
      if (k < 8) begin
        checks++;
        if (wr_count !== 4'(k + 1))
          $display("FAIL fill_count[%0d] got %0d exp %0d",
                   k, wr_count, k + 1);
        else passed++;
        checks++;
        if (full !== (k == 7))
          $display("FAIL fill_full[%0d] got %b exp %b",
                   k, full, (k == 7));
        else passed++;
      end else begin
        checks++;
        if (wr_ptr_gray !== 4'b1100)
          $display("FAIL fill_gray[%0d] got %b exp 1100",
                   k, wr_ptr_gray);
        else passed++;
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0)
          $display("FAIL fill_hold[%0d] got %b exp 1",
                   k, full);
        else passed++;
      end
    end
  endtask

  task automatic test_release;
    in_valid = 1'b1;
    in_data = 16'hBEEF;
    rd_ptr_gray = 4'b0010;
    beef_writes = 0;
    for (int e = 0; e < 3; e++) begin
      #1;
      checks++;
      if (ram_wr_en !== 1'b0)
        $display("FAIL bp_we[%0d] got %b exp 0", e, ram_wr_en);
      else passed++;
      tick();
      checks++;
      if (full !== (e < 2))
        $display("FAIL rel_full[%0d] got %b exp %b",
                 e, full, (e < 2));
      else passed++;
    end
    checks++;
    if (wr_count !== 4'd5)
      $display("FAIL rel_count got %0d exp 5", wr_count);
    else passed++;
    #1;
    checks++;
    if (ram_wr_en !== 1'b1 || ram_wr_ad !== 3'd0 ||
        ram_data_in !== 16'hBEEF)
      $display("FAIL rel_write got %b/%0d/%h exp 1/0/beef",
               ram_wr_en, ram_wr_ad, ram_data_in);
    else passed++;
    tick();
    in_valid = 1'b0;
    checks++;
    if (wr_count !== 4'd6 || full !== 1'b0)
      $display("FAIL rel_after got %0d/%b exp 6/0",
               wr_count, full);
    else passed++;
    checks++;
    if (wr_ptr_gray !== 4'b1101)
      $display("FAIL rel_gray got %b exp 1101", wr_ptr_gray);
    else passed++;
    tick();
    tick();
    checks++;
    if (beef_writes !== 1)
      $display("FAIL bp_once got %0d exp 1", beef_writes);
    else passed++;
  endtask

  task automatic test_clr_mid;
    in_valid = 1'b1;
    in_data = 16'h5555;
    clr = 1'b1;
    #1;
    checks++;
    if (wr_ptr_gray !== 4'b0000 || wr_count !== 4'd0)
      $display("FAIL mid_clr got %b/%0d exp 0000/0",
               wr_ptr_gray, wr_count);
    else passed++;
    checks++;
    if (full !== 1'b0 || in_ready !== 1'b1 ||
        almost_full !== 1'b0)
      $display("FAIL mid_flags got %b%b%b exp 010",
               full, in_ready, almost_full);
    else passed++;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    rd_ptr_gray = 4'h0;
    #1;
    checks++;
    if (wr_ptr_gray !== 4'b0000 || ram_wr_ad !== 3'd0)
      $display("FAIL mid_discard got %b/%0d exp 0000/0",
               wr_ptr_gray, ram_wr_ad);
    else passed++;
    tick();
  endtask

  task automatic test_wrap;
    do_clr();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data = 16'(i);
      rd_ptr_gray = (i >= 2) ? g(i - 2) : 4'h0;
      #1;
      checks++;
      if (ram_wr_en !== 1'b1 || ram_wr_ad !== 3'(i % 8))
        $display("FAIL wrap_ad[%0d] got %b/%0d exp 1/%0d",
                 i, ram_wr_en, ram_wr_ad, i % 8);
      else passed++;
      checks++;
      if (full !== 1'b0)
        $display("FAIL wrap_full[%0d] got %b exp 0", i, full);
      else passed++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (wr_ptr_gray !== 4'b0110)
      $display("FAIL wrap_gray got %b exp 0110", wr_ptr_gray);
    else passed++;
  endtask

  task automatic test_almost_full;
    logic exp_af;
    do_clr();
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data = 16'h2000 + 16'(k);
      tick();
`ifdef ALMOST_FULL_EN
      exp_af = (k == 5);
`else
      exp_af = 1'b0;
`endif
      checks++;
      if (almost_full !== exp_af)
        $display("FAIL af_set[%0d] got %b exp %b",
                 k, almost_full, exp_af);
      else passed++;
    end
    in_valid = 1'b0;
    rd_ptr_gray = 4'b0001;
    for (int e = 0; e < 3; e++) begin
      tick();
`ifdef ALMOST_FULL_EN
      exp_af = (e < 2);
`else
      exp_af = 1'b0;
`endif
      checks++;
      if (almost_full !== exp_af)
        $display("FAIL af_clr[%0d] got %b exp %b",
                 e, almost_full, exp_af);
      else passed++;
    end
    checks++;
    if (wr_count !== 4'd5)
      $display("FAIL af_count got %0d exp 5", wr_count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_release();
    test_clr_mid();
    test_wrap();
    test_almost_full();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
